// File: rtl/spi_master.sv
// SPI master issuing 16-bit {addr, rw, data} frames MSB first, with a
// registered SCLK/CS_N/MOSI interface and read-byte capture.
module spi_master #(
  parameter int HALF_PERIOD = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       sclk,
  output logic       cs_n,
  output logic       mosi,
  input  logic       miso
);

  localparam int HW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HW-1:0] HC_MAX = HW'(HALF_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2,
    GAP   = 2'd3
  } state_t;

  state_t          state_r, state_s;
  logic [HW-1:0]   hcnt_r, hcnt_s;
  logic [4:0]      ecnt_r, ecnt_s;
  logic [15:0]     tx_r, tx_s;
  logic [7:0]      rx_r, rx_s;
  logic            rw_r, rw_s;
  logic            sclk_r, sclk_s;
  logic            cs_n_r, cs_n_s;
  logic            mosi_r, mosi_s;
  logic            busy_r, busy_s;
  logic            done_r, done_s;
  logic [7:0]      rdata_r, rdata_s;
  logic            half_done_s;
  logic [5:0]      edge_num_s;

  assign half_done_s = (hcnt_r == HC_MAX);
  // Number of the SCLK edge produced if this cycle toggles; 32 wraps ecnt to 0.
  assign edge_num_s  = {1'b0, ecnt_r} + 6'd1;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_s = SHIFT;
        else       state_s = IDLE;
      end
      SHIFT: begin
        if (half_done_s && (edge_num_s == 6'd32)) state_s = HOLD;
        else                                      state_s = SHIFT;
      end
      HOLD: begin
        if (half_done_s) state_s = GAP;
        else             state_s = HOLD;
      end
      GAP: begin
        if (half_done_s) state_s = IDLE;
        else             state_s = GAP;
      end
      default: state_s = IDLE;
    endcase
  end

  // Next values of the datapath and of the registered outputs.
  always_comb begin
    hcnt_s  = hcnt_r;
    ecnt_s  = ecnt_r;
    tx_s    = tx_r;
    rx_s    = rx_r;
    rw_s    = rw_r;
    sclk_s  = sclk_r;
    cs_n_s  = cs_n_r;
    mosi_s  = mosi_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    rdata_s = rdata_r;
    case (state_r)
      IDLE: begin
        hcnt_s = '0;
        ecnt_s = 5'd0;
        sclk_s = 1'b0;
        if (start) begin
          tx_s   = {addr, rw, wdata};
          rw_s   = rw;
          busy_s = 1'b1;
          cs_n_s = 1'b0;
          mosi_s = addr[6];
        end else begin
          busy_s = 1'b0;
          cs_n_s = 1'b1;
        end
      end
      SHIFT: begin
        if (half_done_s) begin
          hcnt_s = '0;
          ecnt_s = edge_num_s[4:0];
          sclk_s = ~sclk_r;
          if (!sclk_r) begin
            // Rising edge: the slave samples mosi; read data arrives on edges 17..31.
            if (rw_r && (edge_num_s >= 6'd17)) rx_s = {rx_r[6:0], miso};
            else                               rx_s = rx_r;
          end else begin
            tx_s   = {tx_r[14:0], 1'b0};
            mosi_s = tx_r[14];
          end
        end else begin
          hcnt_s = hcnt_r + HW'(1);
        end
      end
      HOLD: begin
        if (half_done_s) begin
          hcnt_s = '0;
          cs_n_s = 1'b1;
          done_s = 1'b1;
          if (rw_r) rdata_s = rx_r;
          else      rdata_s = rdata_r;
        end else begin
          hcnt_s = hcnt_r + HW'(1);
        end
      end
      GAP: begin
        if (half_done_s) begin
          hcnt_s = '0;
          busy_s = 1'b0;
        end else begin
          hcnt_s = hcnt_r + HW'(1);
        end
      end
      default: begin
        hcnt_s = '0;
        ecnt_s = 5'd0;
      end
    endcase
  end

  // Datapath and output registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      hcnt_r  <= '0;
      ecnt_r  <= 5'd0;
      tx_r    <= 16'h0000;
      rx_r    <= 8'h00;
      rw_r    <= 1'b0;
      sclk_r  <= 1'b0;
      cs_n_r  <= 1'b1;
      mosi_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rdata_r <= 8'h00;
    end else begin
      hcnt_r  <= hcnt_s;
      ecnt_r  <= ecnt_s;
      tx_r    <= tx_s;
      rx_r    <= rx_s;
      rw_r    <= rw_s;
      sclk_r  <= sclk_s;
      cs_n_r  <= cs_n_s;
      mosi_r  <= mosi_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      rdata_r <= rdata_s;
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign rdata = rdata_r;
  assign sclk  = sclk_r;
  assign cs_n  = cs_n_r;
  assign mosi  = mosi_r;

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: two instances (HALF_PERIOD 8 and 32), each with a
// behavioural SPI memory slave; expected frames and read bytes are queued.
module tb_spi_master;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] start, rw, busy, done, sclk, cs_n, mosi, miso;
  logic [6:0] addr  [2];
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  int          frames_a [2];
  int          rises_a  [2];
  int          viol_a   [2];
  logic [15:0] frame_a  [2];

  logic [7:0]  exp_mem   [2][128];
  logic [7:0]  exp_rdata [2];
  logic [15:0] exp_frame_q[$];
  logic [7:0]  exp_rd_q[$];
  int          last_rise_abs, last_t0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_master #(.HALF_PERIOD(8)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start[0]), .rw(rw[0]), .addr(addr[0]),
    .wdata(wdata[0]), .busy(busy[0]), .done(done[0]), .rdata(rdata[0]),
    .sclk(sclk[0]), .cs_n(cs_n[0]), .mosi(mosi[0]), .miso(miso[0])
  );

  spi_master #(.HALF_PERIOD(32)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start[1]), .rw(rw[1]), .addr(addr[1]),
    .wdata(wdata[1]), .busy(busy[1]), .done(done[1]), .rdata(rdata[1]),
    .sclk(sclk[1]), .cs_n(cs_n[1]), .mosi(mosi[1]), .miso(miso[1])
  );

  // Slave memory model plus bus-ordering monitor, sampled on the falling clk edge.
  for (genvar g = 0; g < 2; g++) begin : g_slv
    logic [7:0]  mem [128];
    logic [15:0] sh, frame_q;
    logic [6:0]  addr_q;
    logic        rw_q, miso_q, sclk_d, cs_d, mosi_d;
    int          nbits, rises, viol, frames;

    initial begin
      for (int a = 0; a < 128; a++) mem[a] = 8'h00;
      sh = 16'h0000; frame_q = 16'h0000; addr_q = 7'h00; rw_q = 1'b0;
      miso_q = 1'b0; sclk_d = 1'b0; cs_d = 1'b1; mosi_d = 1'b0;
      nbits = 0; rises = 0; viol = 0; frames = 0;
    end

    always @(negedge clk) begin
      if (!cs_n[g] && cs_d) begin
        nbits = 0; rises = 0; sh = 16'h0000; frames++;
      end
      if (sclk[g] && !sclk_d) begin
        if (cs_n[g] && cs_d) viol++;
        rises++;
        sh = {sh[14:0], mosi[g]};
        nbits++;
        if (nbits == 8) begin
          addr_q = sh[7:1];
          rw_q   = sh[0];
        end
      end
      if (!sclk[g] && sclk_d) begin
        if (cs_n[g] && cs_d) viol++;
        if (rw_q && nbits >= 8 && nbits < 16) miso_q = mem[addr_q][15 - nbits];
        else                                  miso_q = 1'($urandom_range(1, 0));
      end
      if ((mosi[g] !== mosi_d) && sclk[g]) viol++;
      if (cs_n[g] && !cs_d) begin
        if (sclk[g]) viol++;
        frame_q = sh;
        if (nbits == 16 && !sh[8]) mem[sh[15:9]] = sh[7:0];
        rw_q = 1'b0;
      end
      sclk_d = sclk[g];
      cs_d   = cs_n[g];
      mosi_d = mosi[g];
    end

    assign miso[g]     = miso_q;
    assign frames_a[g] = frames;
    assign rises_a[g]  = rises;
    assign viol_a[g]   = viol;
    assign frame_a[g]  = frame_q;
  end

  // One frame on instance i; expects to be called at a falling clk edge.
  task automatic do_frame(input int i, input logic r, input logic [6:0] a,
                          input logic [7:0] d, input bit disturb);
    int h, rel, guard, t0, t_rise, t_done, t_busy, ndone, frames0;
    logic cs0;
    logic [15:0] ef;
    logic [7:0]  er;
    h = (i == 0) ? 8 : 32;
    guard = 0;
    while (busy[i] && guard < 40 * h) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (busy[i] !== 1'b0) begin
      failures++;
      $display("FAIL idle_wait inst=%0d busy=%b required 0", i, busy[i]);
    end
    if (r) begin
      exp_rdata[i] = exp_mem[i][a];
    end else begin
      exp_mem[i][a] = d;
    end
    exp_frame_q.push_back({a, r, d});
    exp_rd_q.push_back(exp_rdata[i]);
    frames0  = frames_a[i];
    start[i] = 1'b1; rw[i] = r; addr[i] = a; wdata[i] = d;
    @(negedge clk);
    start[i] = 1'b0;
    t0 = cyc;
    cs0 = cs_n[i];
    t_rise = -1; t_done = -1; t_busy = -1; ndone = 0;
    for (rel = 0; rel < 34 * h + 20; rel++) begin
      if (rel > 0) @(negedge clk);
      if (disturb && rel == 1) begin
        addr[i] = ~a; wdata[i] = ~d; rw[i] = ~r;
      end
      if (disturb && rel == 49) start[i] = 1'b1;
      if (disturb && rel == 50) start[i] = 1'b0;
      if (rel > 0 && cs_n[i] && t_rise < 0) t_rise = rel;
      if (done[i]) begin
        ndone++;
        if (t_done < 0) t_done = rel;
      end
      if (!busy[i]) begin
        t_busy = rel;
        break;
      end
    end
    last_t0 = t0;
    last_rise_abs = t0 + t_rise;
    ef = exp_frame_q.pop_front();
    er = exp_rd_q.pop_front();
    checks++;
    if (cs0 !== 1'b0) begin
      failures++; $display("FAIL cs_fall inst=%0d cs_n=%b required 0 at T+1", i, cs0);
    end
    checks++;
    if (t_rise !== 33 * h) begin
      failures++; $display("FAIL cs_rise inst=%0d rel=%0d required %0d", i, t_rise, 33 * h);
    end
    checks++;
    if (t_done !== 33 * h || ndone !== 1) begin
      failures++;
      $display("FAIL done_pulse inst=%0d rel=%0d width=%0d required rel=%0d width=1", i, t_done, ndone, 33 * h);
    end
    checks++;
    if (t_busy !== 34 * h) begin
      failures++; $display("FAIL busy_fall inst=%0d rel=%0d required %0d", i, t_busy, 34 * h);
    end
    checks++;
    if (frame_a[i] !== ef) begin
      failures++; $display("FAIL frame_bits inst=%0d got=%h required %h", i, frame_a[i], ef);
    end
    checks++;
    if (rdata[i] !== er) begin
      failures++; $display("FAIL rdata inst=%0d got=%h required %h", i, rdata[i], er);
    end
    checks++;
    if (rises_a[i] !== 16 || frames_a[i] !== frames0 + 1) begin
      failures++;
      $display("FAIL edge_count inst=%0d rises=%0d frames=%0d required 16 and %0d", i, rises_a[i], frames_a[i] - frames0, 1);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 2'b00; rw = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = 7'h00; wdata[i] = 8'h00; exp_rdata[i] = 8'h00;
      for (int a = 0; a < 128; a++) exp_mem[i][a] = 8'h00;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({sclk[i], cs_n[i], mosi[i], busy[i], done[i]} !== 5'b01000) begin
        failures++;
        $display("FAIL reset_ctrl inst=%0d sclk,cs_n,mosi,busy,done=%b required 01000", i,
                 {sclk[i], cs_n[i], mosi[i], busy[i], done[i]});
      end
      checks++;
      if (rdata[i] !== 8'h00) begin
        failures++; $display("FAIL reset_rdata inst=%0d got=%h required 00", i, rdata[i]);
      end
    end
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_write();
    do_frame(0, 1'b0, 7'h15, 8'hA5, 1'b0);
  endtask

  task automatic test_read();
    do_frame(0, 1'b0, 7'h15, 8'h3C, 1'b0);
    do_frame(0, 1'b1, 7'h15, 8'h00, 1'b0);
    do_frame(0, 1'b0, 7'h40, 8'h77, 1'b0);
    do_frame(0, 1'b1, 7'h40, 8'hFF, 1'b0);
  endtask

  task automatic test_edge_order();
    checks++;
    if (viol_a[0] !== 0) begin
      failures++; $display("FAIL edge_order inst=0 violations=%0d required 0", viol_a[0]);
    end
  endtask

  task automatic test_back_to_back();
    int rise_prev;
    do_frame(0, 1'b0, 7'h2A, 8'h96, 1'b1);
    rise_prev = last_rise_abs;
    do_frame(0, 1'b1, 7'h2A, 8'h00, 1'b0);
    checks++;
    if (last_t0 - rise_prev < 8) begin
      failures++; $display("FAIL b2b_gap cs_n high=%0d cycles required >= 8", last_t0 - rise_prev);
    end
  endtask

  task automatic test_reset_midframe();
    int guard, nd;
    start[0] = 1'b1; rw[0] = 1'b1; addr[0] = 7'h2A; wdata[0] = 8'h00;
    @(negedge clk);
    start[0] = 1'b0;
    @(negedge clk);
    guard = 0;
    while (rises_a[0] < 7 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (rises_a[0] < 7) begin
      failures++; $display("FAIL midframe_wait rises=%0d required 7", rises_a[0]);
    end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({cs_n[0], sclk[0], busy[0], done[0]} !== 4'b1000) begin
      failures++;
      $display("FAIL abort_ctrl cs_n,sclk,busy,done=%b required 1000", {cs_n[0], sclk[0], busy[0], done[0]});
    end
    checks++;
    if (rdata[0] !== 8'h00) begin
      failures++; $display("FAIL abort_rdata got=%h required 00", rdata[0]);
    end
    reset_n = 1'b1;
    exp_rdata[0] = 8'h00;
    exp_rdata[1] = 8'h00;
    nd = 0;
    repeat (300) begin
      @(negedge clk);
      if (done[0]) nd++;
    end
    checks++;
    if (nd !== 0 || busy[0] !== 1'b0) begin
      failures++; $display("FAIL abort_done pulses=%0d busy=%b required 0 and 0", nd, busy[0]);
    end
    do_frame(0, 1'b1, 7'h2A, 8'h00, 1'b0);
  endtask

  task automatic test_scale32();
    do_frame(1, 1'b0, 7'h15, 8'h5B, 1'b0);
    do_frame(1, 1'b1, 7'h15, 8'h00, 1'b0);
    do_frame(1, 1'b0, 7'h7F, 8'hC3, 1'b0);
    do_frame(1, 1'b1, 7'h7F, 8'h00, 1'b0);
    checks++;
    if (viol_a[1] !== 0) begin
      failures++; $display("FAIL edge_order inst=1 violations=%0d required 0", viol_a[1]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_edge_order();
    test_back_to_back();
    test_reset_midframe();
    test_scale32();
    test_edge_order();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_master.md
Name: spi_master

Overview:
SPI bus master that issues single-byte read/write transactions to the spiMemory slave over sclk/cs/mosi/miso.
- Accepts a host request: 7-bit address, rw flag, write data.
- Serialises a 16-bit frame MSB first: {addr[6:0], rw, data[7:0]}.
- Captures read data from miso.
- Drives the slave's sclk_pin/cs_pin/mosi_pin and consumes its miso_pin.
- SCLK is slow relative to clk so the slave's input conditioners settle.

Parameters:
HALF_PERIOD, 16, clk cycles per SCLK half-period; legal range >= 8 (covers slave conditioner latency).

Ports:
clk      input   1  system clock; all logic on posedge clk
reset_n  input   1  synchronous, active-low reset
start    input   1  request strobe; accepted only when busy=0
rw       input   1  1 = read, 0 = write; sampled on accept
addr     input   7  target address; sampled on accept
wdata    input   8  write data; sampled on accept (ignored for read)
busy     output  1  high from accept until ready for next start
done     output  1  one-cycle pulse at frame end
rdata    output  8  last read byte; held until next read completes
sclk     output  1  SPI clock, idle low
cs_n     output  1  SPI chip select, active low, idle high
mosi     output  1  master out
miso     input   1  slave out; may be z when slave not driving

Behaviour:
- Reset values (reset_n=0 at posedge clk): state=IDLE, sclk=0, cs_n=1, mosi=0, busy=0, done=0, rdata=0x00, all counters 0.
- Reset wins over everything, including mid-frame: the frame aborts, cs_n=1 and sclk=0 from the next edge, and no done pulse is issued.
- Counters:
  - hcnt counts 0..HALF_PERIOD-1.
  - ecnt counts SCLK edges 0..31.
  - tx shift register 16 bits; rx shift register 8 bits.
- States: IDLE, SHIFT, HOLD, GAP.
- IDLE:
  - start=1 → load tx={addr,rw,wdata}, latch rw, busy=1; next state SHIFT.
  - cs_n=0 and mosi=tx[15] from the next cycle (cycle T+1, where T is the accept edge).
- SHIFT:
  - Each time hcnt reaches HALF_PERIOD-1, toggle sclk, reset hcnt, increment ecnt.
  - Rising edges are odd edges (1,3,...,31); the slave samples mosi there.
  - On a rising edge with ecnt >= 17 (data bits) and latched rw=1: rx <= {rx[6:0], miso}.
  - On a falling edge: tx shifts left and mosi=tx[14] (the new MSB). mosi therefore changes only while sclk is low.
  - After edge 32 (sclk back low) → HOLD.
- HOLD:
  - cs_n stays low, sclk=0, for HALF_PERIOD cycles.
  - Then cs_n=1 and done=1 for exactly one cycle.
  - If latched rw=1, rdata<=rx in the same cycle; for a write, rdata is unchanged.
  - Next state GAP.
- GAP: cs_n=1, busy=1 for HALF_PERIOD cycles, then busy=0 and state IDLE.
- Timing with H=HALF_PERIOD (cycles after T):
  - cs_n falls at T+1.
  - k-th sclk edge at T+1+k*H.
  - cs_n rises and done fires at T+1+33H.
  - busy falls at T+1+34H.
- start while busy=1 is ignored; no queuing.
- addr/rw/wdata changes after accept have no effect.
- miso value during the address byte and during writes is don't-care (ignored even if x/z).

Test Plan:
1. H=8; write addr=0x15, wdata=0xA5 → mosi sampled on the 16 rising sclk edges = 0010101_0_10100101; cs_n low from T+1 to T+264; done single pulse at T+265; busy low at T+273; rdata stays 0x00.
2. Read addr=0x15 against a slave model (or spiMemory) holding 0x3C → frame bits 0010101_1; rdata=0x3C at done; rdata unchanged by a subsequent write.
3. Edge-ordering check → mosi transitions only while sclk=0; no sclk edge while cs_n=1; exactly 16 rising edges per frame; sclk=0 at cs_n rise.
4. Pulse start again at T+50, and change addr/wdata at T+2 → no second frame and the original frame bits are unchanged; a start asserted exactly when busy falls is accepted, giving back-to-back frames with cs_n high for >=H cycles between them.
5. Assert reset_n=0 after the 7th rising edge → next cycle cs_n=1, sclk=0, busy=0, done never pulses, rdata=0x00; a fresh read then completes correctly.
6. Repeat 1–2 with HALF_PERIOD=8 and 32 → timing scales per the formulas; the spiMemory slave returns written data correctly at both settings.
